// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: ID-side inputs, forwarding selects and EX-side registered outputs.
interface id_ex_operand_stage_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int CW  = 4,
  parameter int SCW = 16
);
  logic          id_valid;
  logic [AW-1:0] id_rs_addr;
  logic [AW-1:0] id_rt_addr;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [AW-1:0] id_w_addr;
  logic          id_write_reg;
  logic          id_mem_read;
  logic [CW-1:0] id_alu_ctrl;
  logic [1:0]    fwd1;
  logic [1:0]    fwd2;
  logic [DW-1:0] ex_result;
  logic [DW-1:0] mem_result;
  logic          flush;
  logic          hold;
  logic           stall_req;
  logic           ex_valid;
  logic [DW-1:0]  ex_op_a;
  logic [DW-1:0]  ex_op_b;
  logic [DW-1:0]  ex_imm;
  logic [AW-1:0]  ex_w_addr;
  logic           ex_write_reg;
  logic           ex_mem_read;
  logic [CW-1:0]  ex_alu_ctrl;
  logic [SCW-1:0] stall_cnt;
  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
           id_w_addr, id_write_reg, id_mem_read, id_alu_ctrl, fwd1, fwd2,
           ex_result, mem_result, flush, hold,
    output stall_req, ex_valid, ex_op_a, ex_op_b, ex_imm, ex_w_addr,
           ex_write_reg, ex_mem_read, ex_alu_ctrl, stall_cnt
  );
  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
           id_w_addr, id_write_reg, id_mem_read, id_alu_ctrl, fwd1, fwd2,
           ex_result, mem_result, flush, hold,
    input  stall_req, ex_valid, ex_op_a, ex_op_b, ex_imm, ex_w_addr,
           ex_write_reg, ex_mem_read, ex_alu_ctrl, stall_cnt
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with operand forwarding muxes and load-use bubble insertion.
module id_ex_operand_stage #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int CW  = 4,
  parameter int SCW = 16
) (
  input logic clk,
  input logic rst_n,
  id_ex_operand_stage_if.slave bus
);
  localparam logic [1:0] EX_FWD  = 2'b01;
  localparam logic [1:0] MEM_FWD = 2'b10;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          luh;
  always_comb begin
    opa = bus.fwd1 == EX_FWD ? bus.ex_result : bus.fwd1 == MEM_FWD ? bus.mem_result : bus.id_rs_data;
    opb = bus.fwd2 == EX_FWD ? bus.ex_result : bus.fwd2 == MEM_FWD ? bus.mem_result : bus.id_rt_data;
  end
  // a load into $0 never produces a usable value, so it cannot be a hazard source
  assign luh = bus.id_valid & bus.ex_valid & bus.ex_mem_read & (|bus.ex_w_addr) &
               (bus.ex_w_addr == bus.id_rs_addr | bus.ex_w_addr == bus.id_rt_addr);
  assign bus.stall_req = luh & ~bus.flush & ~bus.hold;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_op_a      <= '0;
      bus.ex_op_b      <= '0;
      bus.ex_imm       <= '0;
      bus.ex_w_addr    <= '0;
      bus.ex_write_reg <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_alu_ctrl  <= '0;
      bus.stall_cnt    <= '0;
    end else if (bus.flush || (!bus.hold && luh)) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_op_a      <= '0;
      bus.ex_op_b      <= '0;
      bus.ex_imm       <= '0;
      bus.ex_w_addr    <= '0;
      bus.ex_write_reg <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_alu_ctrl  <= '0;
      if (!bus.flush && !(&bus.stall_cnt)) bus.stall_cnt <= bus.stall_cnt + SCW'(1);
    end else if (!bus.hold) begin
      bus.ex_valid     <= bus.id_valid;
      bus.ex_op_a      <= opa;
      bus.ex_op_b      <= opb;
      bus.ex_imm       <= bus.id_imm;
      bus.ex_w_addr    <= bus.id_w_addr;
      bus.ex_write_reg <= bus.id_valid & bus.id_write_reg;
      bus.ex_mem_read  <= bus.id_valid & bus.id_mem_read;
      bus.ex_alu_ctrl  <= bus.id_alu_ctrl;
    end
  end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and randomized checks against a cycle-level reference model.
module tb_id_ex_operand_stage;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int CW  = 4;
  localparam int SCW = 8;
  typedef struct packed {
    logic           v;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [DW-1:0]  imm;
    logic [AW-1:0]  wa;
    logic           wr;
    logic           mr;
    logic [CW-1:0]  ctrl;
    logic [SCW-1:0] cnt;
  } st_t;
  logic clk = 1'b0;
  logic rst_n;
  st_t  m;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  id_ex_operand_stage_if #(.DW(DW), .AW(AW), .CW(CW), .SCW(SCW)) bus ();
  id_ex_operand_stage #(.DW(DW), .AW(AW), .CW(CW), .SCW(SCW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic st_t snap();
    return {bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_imm, bus.ex_w_addr,
            bus.ex_write_reg, bus.ex_mem_read, bus.ex_alu_ctrl, bus.stall_cnt};
  endfunction
  function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] rf);
    case (sel)
      2'd1:    return bus.ex_result;
      2'd2:    return bus.mem_result;
      default: return rf;
    endcase
  endfunction
  function automatic logic model_hazard();
    return bus.id_valid && m.v && m.mr && m.wa != 0 && (m.wa == bus.id_rs_addr || m.wa == bus.id_rt_addr);
  endfunction
  function automatic logic model_stall();
    return model_hazard() && !bus.flush && !bus.hold;
  endfunction
  task automatic tick();
    st_t n;
    n = m;
    if (!rst_n) n = '0;
    else if (bus.flush || (!bus.hold && model_hazard())) begin
      n = '0;
      n.cnt = m.cnt;
      if (!bus.flush && m.cnt != {SCW{1'b1}}) n.cnt = m.cnt + 1;
    end else if (!bus.hold) begin
      n.v    = bus.id_valid;
      n.a    = pick(bus.fwd1, bus.id_rs_data);
      n.b    = pick(bus.fwd2, bus.id_rt_data);
      n.imm  = bus.id_imm;
      n.wa   = bus.id_w_addr;
      n.wr   = bus.id_valid && bus.id_write_reg;
      n.mr   = bus.id_valid && bus.id_mem_read;
      n.ctrl = bus.id_alu_ctrl;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask
  task automatic id(input logic v, input logic [AW-1:0] rs, rt, w, input logic mr);
    bus.id_valid     = v;
    bus.id_rs_addr   = rs;
    bus.id_rt_addr   = rt;
    bus.id_w_addr    = w;
    bus.id_mem_read  = mr;
    bus.id_write_reg = 1'b1;
    bus.id_rs_data   = $urandom;
    bus.id_rt_data   = $urandom;
    bus.id_imm       = $urandom;
    bus.id_alu_ctrl  = CW'($urandom);
    bus.ex_result    = $urandom;
    bus.mem_result   = $urandom;
    bus.fwd1         = 2'd0;
    bus.fwd2         = 2'd0;
    bus.flush        = 1'b0;
    bus.hold         = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      id(1'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom));
      bus.fwd1 = 2'($urandom);
      bus.fwd2 = 2'($urandom);
      tick();
    end
    checks++;
    if (snap() !== st_t'(0)) begin errors++; $display("FAIL reset_regs got %h want 0", snap()); end
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall_req); end
    rst_n = 1'b1;
  endtask
  task automatic test_forward();
    logic [DW-1:0] want [4];
    want = '{32'h11, 32'h22, 32'h33, 32'h11};
    for (int s = 0; s < 2; s++)
      for (int f = 0; f < 4; f++) begin
        id(1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
        bus.id_rs_data = 32'h11;
        bus.id_rt_data = 32'h11;
        bus.ex_result  = 32'h22;
        bus.mem_result = 32'h33;
        if (s == 0) bus.fwd1 = 2'(f); else bus.fwd2 = 2'(f);
        tick();
        checks++;
        if ((s == 0 ? bus.ex_op_a : bus.ex_op_b) !== want[f])
          begin errors++; $display("FAIL fwd%0d_sel%0d got %h want %h", s + 1, f, s == 0 ? bus.ex_op_a : bus.ex_op_b, want[f]); end
      end
  endtask
  task automatic test_load_use();
    rst_n = 1'b0;
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1);
    tick();
    id(1'b1, 5'd3, 5'd8, 5'd9, 1'b0);
    #1;
    checks++;
    if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", bus.stall_req); end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.stall_cnt !== SCW'(1))
      begin errors++; $display("FAIL lu_bubble got valid=%b cnt=%0d want valid=0 cnt=1", bus.ex_valid, bus.stall_cnt); end
    bus.fwd2 = 2'd2;
    bus.mem_result = 32'hABCD;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %b want 0", bus.stall_req); end
    tick();
    checks++;
    if (bus.ex_op_b !== 32'hABCD || bus.ex_valid !== 1'b1)
      begin errors++; $display("FAIL lu_mem_fwd got b=%h valid=%b want b=0000abcd valid=1", bus.ex_op_b, bus.ex_valid); end
  endtask
  task automatic test_zero_guard();
    id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1);
    tick();
    id(1'b1, 5'd0, 5'd0, 5'd4, 1'b0);
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL zero_stall got %b want 0", bus.stall_req); end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || snap() !== m) begin errors++; $display("FAIL zero_nobubble got %h want %h", snap(), m); end
  endtask
  task automatic test_flush_hold();
    st_t saved;
    id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    id(1'b1, 5'd1, 5'd2, 5'd6, 1'b0);
    bus.flush = 1'b1;
    bus.hold  = 1'b1;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_op_a !== '0 || bus.ex_w_addr !== '0)
      begin errors++; $display("FAIL flush_over_hold got %h want bubble", snap()); end
    id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    saved = snap();
    for (int i = 0; i < 3; i++) begin
      id(1'b1, 5'd5, 5'd5, AW'($urandom), 1'($urandom));
      bus.fwd1 = 2'($urandom);
      bus.hold = 1'b1;
      #1;
      checks++;
      if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL hold_stall%0d got %b want 0", i, bus.stall_req); end
      tick();
      checks++;
      if (snap() !== saved || snap() !== m) begin errors++; $display("FAIL hold_keep%0d got %h want %h", i, snap(), saved); end
    end
  endtask
  task automatic test_back_to_back();
    logic [SCW-1:0] c0;
    c0 = m.cnt;
    id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1);
    tick();
    id(1'b1, 5'd8, 5'd2, 5'd9, 1'b1);
    tick();
    bus.fwd1 = 2'd2;
    tick();
    id(1'b1, 5'd3, 5'd9, 5'd10, 1'b0);
    tick();
    bus.fwd2 = 2'd2;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL b2b_release got %b want 0", bus.stall_req); end
    tick();
    checks++;
    if (bus.stall_cnt !== c0 + SCW'(2) || bus.ex_valid !== 1'b1)
      begin errors++; $display("FAIL b2b_count got cnt=%0d valid=%b want cnt=%0d valid=1", bus.stall_cnt, bus.ex_valid, c0 + 2); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      id($urandom_range(0, 7) != 0, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
         AW'($urandom_range(0, 3)), 1'($urandom));
      bus.id_write_reg = 1'($urandom);
      bus.fwd1  = 2'($urandom);
      bus.fwd2  = 2'($urandom);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.hold  = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (bus.stall_req !== model_stall()) begin errors++; $display("FAIL rnd_stall%0d got %b want %b", i, bus.stall_req, model_stall()); end
      tick();
      checks++;
      if (snap() !== m) begin errors++; $display("FAIL rnd_regs%0d got %h want %h", i, snap(), m); end
    end
    rst_n = 1'b1;
  endtask
  task automatic test_saturation();
    for (int i = 0; i < (1 << SCW) + 5; i++) begin
      id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1);
      tick();
      id(1'b1, 5'd8, 5'd8, 5'd9, 1'b0);
      tick();
    end
    checks++;
    if (bus.stall_cnt !== {SCW{1'b1}} || snap() !== m)
      begin errors++; $display("FAIL sat_cnt got %h want %h", bus.stall_cnt, {SCW{1'b1}}); end
  endtask
  initial begin
    m = '0;
    test_reset();
    test_forward();
    test_load_use();
    test_zero_guard();
    test_flush_hold();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
